// File: rtl/eth_mac_stats_counter.sv
// eth_mac_stats_counter
//   Per-channel event counters for MAC/FIFO status pulses. Live counters run
//   continuously; a snapshot strobe copies every live counter and its sticky
//   overflow flag into a shadow register. A one-deep valid/ready read port
//   serves shadow values to the management side.
//
//   Build option: define ETH_STATS_SATURATE_EN to make the counters saturate
//   at all-ones instead of wrapping. Without it, counters wrap modulo
//   2**COUNT_WIDTH. In both modes the sticky overflow flag is set on the
//   event that runs past all-ones.
module eth_mac_stats_counter #(
  parameter int NUM_CHANNELS = 16,
  parameter int COUNT_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] event_in,
  input  logic                    snapshot,
  input  logic                    clear_on_snap,
  input  logic [ADDR_WIDTH-1:0]   s_rd_addr,
  input  logic                    s_rd_valid,
  output logic                    s_rd_ready,
  output logic [COUNT_WIDTH-1:0]  m_rd_data,
  output logic                    m_rd_ovf,
  output logic                    m_rd_err,
  output logic                    m_rd_valid,
  input  logic                    m_rd_ready
);

  typedef enum logic {IDLE, RESP} state_t;

  logic [COUNT_WIDTH-1:0]  shadow_bus [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] shadow_ovf_bus;

  state_t                  state_reg;
  logic                    rdy_en_reg;
  logic                    accept;
  logic                    in_range;
  logic [COUNT_WIDTH-1:0]  rd_sel_data;
  logic                    rd_sel_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [COUNT_WIDTH-1:0] live_reg;
      logic                   live_ovf_reg;
      logic [COUNT_WIDTH-1:0] shadow_reg;
      logic                   shadow_ovf_reg;
      logic                   inc;
      logic                   at_max;

      assign inc    = event_in[gi];
      assign at_max = &live_reg;

      // Live counter: a clearing snapshot restarts the interval with this
      // cycle's event so an event coinciding with the snapshot is never lost.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          live_reg     <= '0;
          live_ovf_reg <= 1'b0;
        end else if (snapshot && clear_on_snap) begin
          live_reg     <= COUNT_WIDTH'(inc);
          live_ovf_reg <= 1'b0;
        end else if (inc) begin
`ifdef ETH_STATS_SATURATE_EN
          if (at_max) begin
            live_ovf_reg <= 1'b1;
          end else begin
            live_reg <= live_reg + COUNT_WIDTH'(1);
          end
`else
          live_reg <= live_reg + COUNT_WIDTH'(1);
          if (at_max) begin
            live_ovf_reg <= 1'b1;
          end
`endif
        end
      end

      // Shadow copy captures the live value before this cycle's increment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg     <= '0;
          shadow_ovf_reg <= 1'b0;
        end else if (snapshot) begin
          shadow_reg     <= live_reg;
          shadow_ovf_reg <= live_ovf_reg;
        end
      end

      assign shadow_bus[gi]     = shadow_reg;
      assign shadow_ovf_bus[gi] = shadow_ovf_reg;
    end
  endgenerate

  // Request side is ready when idle, or when the pending response retires
  // this cycle; held low until the first edge after reset release.
  assign s_rd_ready = rdy_en_reg & ((state_reg == IDLE) | m_rd_ready);
  assign accept     = s_rd_valid & s_rd_ready;
  assign in_range   = (32'(s_rd_addr) < NUM_CHANNELS);

  // Shadow read mux; out-of-range addresses fall through to zero.
  always_comb begin
    rd_sel_data = '0;
    rd_sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (s_rd_addr == ADDR_WIDTH'(i)) begin
        rd_sel_data = shadow_bus[i];
        rd_sel_ovf  = shadow_ovf_bus[i];
      end
    end
  end

  // Read FSM: latch a response on accept, hold it until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rdy_en_reg <= 1'b0;
      m_rd_valid <= 1'b0;
      m_rd_data  <= '0;
      m_rd_ovf   <= 1'b0;
      m_rd_err   <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
      if (accept) begin
        state_reg  <= RESP;
        m_rd_valid <= 1'b1;
        m_rd_data  <= in_range ? rd_sel_data : '0;
        m_rd_ovf   <= in_range ? rd_sel_ovf : 1'b0;
        m_rd_err   <= ~in_range;
      end else if ((state_reg == RESP) && m_rd_ready) begin
        state_reg  <= IDLE;
        m_rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_mac_stats_counter.sv
// tb_eth_mac_stats_counter
//   Scoreboard bench: read requests push their expected response into a
//   queue; a monitor pops and compares on every consumed response, and also
//   checks accept-to-valid latency and response stability under backpressure.
//   Expectations follow ETH_STATS_SATURATE_EN when it is defined.
module tb_eth_mac_stats_counter;

  localparam int NCH = 12;
  localparam int CW  = 4;
  localparam int AW  = 4;

`ifdef ETH_STATS_SATURATE_EN
  localparam logic [CW-1:0] OVF_DATA = 4'd15;
`else
  localparam logic [CW-1:0] OVF_DATA = 4'd1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] event_in = '0;
  logic           snapshot = 1'b0;
  logic           clear_on_snap = 1'b0;
  logic [AW-1:0]  s_rd_addr = '0;
  logic           s_rd_valid = 1'b0;
  logic           s_rd_ready;
  logic [CW-1:0]  m_rd_data;
  logic           m_rd_ovf;
  logic           m_rd_err;
  logic           m_rd_valid;
  logic           m_rd_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  int resp_count = 0;
  int exp_resp = 0;

  logic [CW+1:0] sb [$];

  eth_mac_stats_counter #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .snapshot(snapshot),
    .clear_on_snap(clear_on_snap), .s_rd_addr(s_rd_addr), .s_rd_valid(s_rd_valid),
    .s_rd_ready(s_rd_ready), .m_rd_data(m_rd_data), .m_rd_ovf(m_rd_ovf),
    .m_rd_err(m_rd_err), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency, stability and scoreboard comparison at the negedge.
  logic          acc_pend = 1'b0;
  logic          hold = 1'b0;
  logic [CW+1:0] held = '0;
  logic [CW+1:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_pend = 1'b0;
      hold     = 1'b0;
    end else begin
      if (acc_pend) check("latency_valid", 32'(m_rd_valid), 32'd1);
      if (hold) check("stable_resp", 32'({m_rd_err, m_rd_ovf, m_rd_data}), 32'(held));
      if (m_rd_valid && m_rd_ready) begin
        resp_count++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_resp: got %0h expected none", {m_rd_err, m_rd_ovf, m_rd_data});
        end else begin
          exp_v = sb.pop_front();
          check("resp {err,ovf,data}", 32'({m_rd_err, m_rd_ovf, m_rd_data}), 32'(exp_v));
          $display("[TB] resp #%0d err=%0d ovf=%0d data=%0d", resp_count, m_rd_err, m_rd_ovf, m_rd_data);
        end
      end
      hold     = m_rd_valid && !m_rd_ready;
      held     = {m_rd_err, m_rd_ovf, m_rd_data};
      acc_pend = s_rd_valid && s_rd_ready;
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic ev(input logic [NCH-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      event_in = mask;
      @(posedge clk); #1;
    end
    event_in = '0;
  endtask

  task automatic snap(input logic clr, input logic [NCH-1:0] mask);
    snapshot = 1'b1;
    clear_on_snap = clr;
    event_in = mask;
    @(posedge clk); #1;
    snapshot = 1'b0;
    clear_on_snap = 1'b0;
    event_in = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [CW-1:0] d, input logic o, input logic e);
    bit done;
    done = 1'b0;
    sb.push_back({e, o, d});
    exp_resp++;
    s_rd_addr  = a;
    s_rd_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (s_rd_ready) done = 1'b1;
    end
    @(posedge clk); #1;
    s_rd_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL rd_accept_timeout: addr %0d not accepted, required accept", a);
    end
  endtask

  initial begin
    int base;
    int n;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(m_rd_valid), 32'd0);
    check("rst_data", 32'(m_rd_data), 32'd0);
    check("rst_ovf_err", 32'({m_rd_ovf, m_rd_err}), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rdy_after_rst", 32'(s_rd_ready), 32'd1);

    // Counting, including simultaneous events
    ev(12'b0101, 2);
    ev(12'b0001, 3);
    ev(12'b0100, 1);
    snap(1'b0, '0);
    rd(4'd0, 4'd5, 1'b0, 1'b0);
    rd(4'd2, 4'd3, 1'b0, 1'b0);

    // Clear race: event in the clearing snapshot cycle lands in new interval
    ev(12'b0010, 7);
    snap(1'b1, 12'b0010);
    rd(4'd1, 4'd7, 1'b0, 1'b0);
    snap(1'b0, '0);
    rd(4'd1, 4'd1, 1'b0, 1'b0);
    rd(4'd0, 4'd0, 1'b0, 1'b0);

    // Overflow on ch3, then clear_on_snap zeroes the flag
    ev(12'b1000, 17);
    snap(1'b0, '0);
    rd(4'd3, OVF_DATA, 1'b1, 1'b0);
    snap(1'b1, '0);
    rd(4'd3, OVF_DATA, 1'b1, 1'b0);
    snap(1'b0, '0);
    rd(4'd3, 4'd0, 1'b0, 1'b0);

    // Snapshot in the accept cycle returns the old shadow value
    ev(12'b1_0000, 2);
    sb.push_back({1'b0, 1'b0, 4'd0});
    exp_resp++;
    s_rd_addr = 4'd4;
    s_rd_valid = 1'b1;
    snapshot = 1'b1;
    @(negedge clk);
    check("snap_accept_rdy", 32'(s_rd_ready), 32'd1);
    @(posedge clk); #1;
    s_rd_valid = 1'b0;
    snapshot = 1'b0;
    rd(4'd4, 4'd2, 1'b0, 1'b0);

    // Back-to-back reads with a 4-cycle stall on the second response
    @(posedge clk); #1;
    base = resp_count;
    fork
      begin
        rd(4'd3, 4'd0, 1'b0, 1'b0);
        rd(4'd4, 4'd2, 1'b0, 1'b0);
        rd(4'd15, 4'd0, 1'b0, 1'b1);
      end
      begin
        n = 0;
        while (resp_count < base + 1 && n < 50) begin
          @(negedge clk); #1;
          n++;
        end
        check("stall_reached", 32'(resp_count >= base + 1), 32'd1);
        @(posedge clk); #1;
        m_rd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_s_rd_ready", 32'(s_rd_ready), 32'd0);
          check("stall_valid_data", 32'({m_rd_valid, m_rd_data}), 32'({1'b1, 4'd2}));
        end
        @(posedge clk); #1;
        m_rd_ready = 1'b1;
      end
    join
    rd(4'd12, 4'd0, 1'b0, 1'b1);
    rd(4'd11, 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Reset asserted while a response is pending
    m_rd_ready = 1'b0;
    rd(4'd4, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 32'(m_rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(m_rd_valid), 32'd0);
    check("async_rst_outs", 32'({m_rd_err, m_rd_ovf, m_rd_data}), 32'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    exp_resp--;
    @(negedge clk); #2;
    rst_n = 1'b1;
    m_rd_ready = 1'b1;
    @(posedge clk); #1;
    check("rdy_after_rst2", 32'(s_rd_ready), 32'd1);
    rd(4'd4, 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    check("resp_count", 32'(resp_count), 32'(exp_resp));
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
